// File: rtl/histo_pkg.sv
// Shared definitions for the pixel histogram block: parameter defaults,
// controller state encoding and the saturating bin increment.
package histo_pkg;

  localparam int PIX_W_DEF    = 10;
  localparam int BIN_BITS_DEF = 8;
  localparam int CNT_W_DEF    = 24;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DUMP  = 3'd4
  } histo_state_t;

  // Callers zero-extend their counter into 64 bits and truncate the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    if (val >= max_val) begin
      sat_inc = max_val;
    end else begin
      sat_inc = val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/histo_bin_ram.sv
// Histogram bin storage: one write port and one synchronous read port,
// written in the plain form that maps onto block RAM.
module histo_bin_ram #(
  parameter int AW = 8,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Write port and registered read port; no reset so the array stays in RAM.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/pixel_histogram.sv
// Per-frame intensity histogram: bins valid pixels through a forwarded
// read-modify-write pipeline, then streams and clears every bin after frame end.
module pixel_histogram
  import histo_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int BIN_BITS = BIN_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk_i,
  input  logic                reset,
  input  logic [PIX_W-1:0]    pd_i,
  input  logic                fv_i,
  input  logic                lv_i,
  output logic                hist_valid_o,
  input  logic                hist_ready_i,
  output logic [BIN_BITS-1:0] hist_bin_o,
  output logic [CNT_W-1:0]    hist_count_o,
  output logic                hist_last_o,
  output logic                frame_drop_o,
  output logic                busy_o
);

  localparam logic [BIN_BITS-1:0] LAST_BIN = {BIN_BITS{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  histo_state_t state_r, state_s;
  logic                fv_r, fv_rise_s, fv_fall_s, count_s, drain_r;
  logic [BIN_BITS-1:0] pix_bin_s, clr_addr_r;
  logic                s0_v_r, s1_v_r;
  logic [BIN_BITS-1:0] s0_bin_r, s1_bin_r;
  logic [CNT_W-1:0]    s1_cnt_r, cur_s, inc_s;
  logic [BIN_BITS-1:0] rd_ptr_r, rd_bin_r;
  logic                rd_done_r, rdv_r, issue_s, pop_s;
  logic [1:0]          occ_s;
  logic                out_v_r, out_last_r, skid_v_r, skid_last_r;
  logic [BIN_BITS-1:0] out_bin_r, skid_bin_r;
  logic [CNT_W-1:0]    out_cnt_r, skid_cnt_r;
  logic                drop_r, busy_r;
  logic                ram_we_s;
  logic [BIN_BITS-1:0] ram_waddr_s, ram_raddr_s;
  logic [CNT_W-1:0]    ram_wdata_s, ram_rdata_s;

  assign pix_bin_s = pd_i[PIX_W-1 -: BIN_BITS];
  assign fv_rise_s = fv_i & ~fv_r;
  assign fv_fall_s = ~fv_i & fv_r;
  assign pop_s     = out_v_r & hist_ready_i;

  if (PIX_W > BIN_BITS) begin : g_low_bits
    logic unused_s;
    assign unused_s = ^pd_i[PIX_W-BIN_BITS-1:0];
  end

  histo_bin_ram #(.AW(BIN_BITS), .DW(CNT_W)) u_ram (
    .clk_i (clk_i),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Next-state logic of the frame controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: if (clr_addr_r == LAST_BIN) state_s = ST_IDLE;  else state_s = ST_CLEAR;
      ST_IDLE:  if (fv_rise_s)              state_s = ST_ACCUM; else state_s = ST_IDLE;
      ST_ACCUM: if (fv_fall_s)              state_s = ST_DRAIN; else state_s = ST_ACCUM;
      ST_DRAIN: if (drain_r)                state_s = ST_DUMP;  else state_s = ST_DRAIN;
      ST_DUMP:  if (pop_s && out_last_r)    state_s = ST_IDLE;  else state_s = ST_DUMP;
      default:                              state_s = ST_CLEAR;
    endcase
  end

  // Pixel qualification, forwarding, dump read credit and RAM port muxing.
  always_comb begin
    count_s     = fv_i & lv_i & ((state_r == ST_ACCUM) | ((state_r == ST_IDLE) & fv_rise_s));
    // The last write may collide with this bin's read, so take it from the pipeline.
    cur_s       = (s1_v_r && (s1_bin_r == s0_bin_r)) ? s1_cnt_r : ram_rdata_s;
    inc_s       = CNT_W'(sat_inc(64'(cur_s), 64'(CNT_MAX)));
    occ_s       = {1'b0, out_v_r} + {1'b0, skid_v_r} + {1'b0, rdv_r};
    issue_s     = (state_r == ST_DUMP) & ~rd_done_r & ((occ_s - {1'b0, pop_s}) < 2'd2);
    ram_raddr_s = (state_r == ST_DUMP) ? rd_ptr_r : pix_bin_s;
    ram_we_s    = 1'b0;
    ram_waddr_s = '0;
    ram_wdata_s = '0;
    if (state_r == ST_CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_r;
    end else if (s0_v_r) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = s0_bin_r;
      ram_wdata_s = inc_s;
    end else if (rdv_r) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = rd_bin_r;
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  // Controller state, RMW pipeline, dump read pointer and status outputs.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_r    <= ST_CLEAR;
      fv_r       <= 1'b0;
      clr_addr_r <= '0;
      drain_r    <= 1'b0;
      s0_v_r     <= 1'b0;
      s0_bin_r   <= '0;
      s1_v_r     <= 1'b0;
      s1_bin_r   <= '0;
      s1_cnt_r   <= '0;
      rd_ptr_r   <= '0;
      rd_done_r  <= 1'b0;
      rdv_r      <= 1'b0;
      rd_bin_r   <= '0;
      drop_r     <= 1'b0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      fv_r       <= fv_i;
      clr_addr_r <= (state_r == ST_CLEAR) ? clr_addr_r + BIN_BITS'(1) : '0;
      drain_r    <= (state_r == ST_DRAIN) & ~drain_r;
      s0_v_r     <= count_s;
      s0_bin_r   <= pix_bin_s;
      s1_v_r     <= s0_v_r;
      s1_bin_r   <= s0_bin_r;
      s1_cnt_r   <= inc_s;
      if (state_r != ST_DUMP) begin
        rd_ptr_r  <= '0;
        rd_done_r <= 1'b0;
      end else if (issue_s) begin
        rd_ptr_r  <= rd_ptr_r + BIN_BITS'(1);
        rd_done_r <= (rd_ptr_r == LAST_BIN);
      end
      rdv_r    <= issue_s;
      rd_bin_r <= rd_ptr_r;
      drop_r   <= fv_rise_s & (state_r inside {ST_CLEAR, ST_DRAIN, ST_DUMP});
      busy_r   <= ~((state_s == ST_IDLE) | (state_s == ST_ACCUM));
    end
  end

  // Output word register with one skid entry behind it.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      out_v_r     <= 1'b0;
      out_bin_r   <= '0;
      out_cnt_r   <= '0;
      out_last_r  <= 1'b0;
      skid_v_r    <= 1'b0;
      skid_bin_r  <= '0;
      skid_cnt_r  <= '0;
      skid_last_r <= 1'b0;
    end else if (pop_s) begin
      if (skid_v_r) begin
        out_bin_r  <= skid_bin_r;
        out_cnt_r  <= skid_cnt_r;
        out_last_r <= skid_last_r;
        if (rdv_r) begin
          skid_bin_r  <= rd_bin_r;
          skid_cnt_r  <= ram_rdata_s;
          skid_last_r <= (rd_bin_r == LAST_BIN);
        end else begin
          skid_v_r <= 1'b0;
        end
      end else if (rdv_r) begin
        out_bin_r  <= rd_bin_r;
        out_cnt_r  <= ram_rdata_s;
        out_last_r <= (rd_bin_r == LAST_BIN);
      end else begin
        out_v_r    <= 1'b0;
        out_last_r <= 1'b0;
      end
    end else if (rdv_r) begin
      if (!out_v_r) begin
        out_v_r    <= 1'b1;
        out_bin_r  <= rd_bin_r;
        out_cnt_r  <= ram_rdata_s;
        out_last_r <= (rd_bin_r == LAST_BIN);
      end else begin
        skid_v_r    <= 1'b1;
        skid_bin_r  <= rd_bin_r;
        skid_cnt_r  <= ram_rdata_s;
        skid_last_r <= (rd_bin_r == LAST_BIN);
      end
    end
  end

  assign hist_valid_o = out_v_r;
  assign hist_bin_o   = out_bin_r;
  assign hist_count_o = out_cnt_r;
  assign hist_last_o  = out_last_r;
  assign frame_drop_o = drop_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_pixel_histogram.sv
// Self-checking bench for pixel_histogram: drives frames, keeps a per-bin
// reference histogram and checks every accepted dump word against it.
module tb_pixel_histogram;

  localparam int PIX_W = 10;
  localparam int BIN_BITS = 8;
  localparam int CNT_W = 24;
  localparam int NB = 256;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  logic [PIX_W-1:0] pd_i = '0;
  logic fv_i = 1'b0;
  logic lv_i = 1'b0;
  logic hist_ready_i = 1'b1;
  logic hist_valid_o, hist_last_o, frame_drop_o, busy_o;
  logic [BIN_BITS-1:0] hist_bin_o;
  logic [CNT_W-1:0] hist_count_o;

  always #5 clk_i = ~clk_i;

  pixel_histogram #(.PIX_W(PIX_W), .BIN_BITS(BIN_BITS), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset(reset), .pd_i(pd_i), .fv_i(fv_i), .lv_i(lv_i),
    .hist_valid_o(hist_valid_o), .hist_ready_i(hist_ready_i), .hist_bin_o(hist_bin_o),
    .hist_count_o(hist_count_o), .hist_last_o(hist_last_o),
    .frame_drop_o(frame_drop_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail = 0;
  int model_hist[NB];
  int exp_hist[NB];
  int got_hist[NB];
  bit dump_expect = 1'b0;
  bit rand_ready = 1'b0;
  int words_seen = 0;
  int last_seen = 0;
  int drop_seen = 0;
  longint got_sum = 0;
  int npix = 0;
  logic [PIX_W-1:0] frame_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  always @(posedge clk_i) begin
    #1;
    hist_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: dump words against the snapshot, stall stability, idle quiet.
  logic prev_v = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [BIN_BITS-1:0] prev_bin = '0;
  logic [CNT_W-1:0] prev_cnt = '0;
  always @(negedge clk_i) begin
    if (frame_drop_o) drop_seen++;
    if (!dump_expect) check("idle_valid", hist_valid_o, 0);
    if (prev_v && !prev_rdy) begin
      check("stall_valid", hist_valid_o, 1);
      check("stall_bin", hist_bin_o, prev_bin);
      check("stall_count", hist_count_o, prev_cnt);
      check("stall_last", hist_last_o, prev_last);
    end
    if (dump_expect && hist_valid_o && hist_ready_i) begin
      check("dump_bin", hist_bin_o, words_seen);
      check("dump_count", hist_count_o, exp_hist[words_seen]);
      check("dump_last", hist_last_o, (words_seen == NB - 1) ? 1 : 0);
      got_hist[hist_bin_o] = int'(hist_count_o);
      got_sum += longint'(hist_count_o);
      if (hist_last_o) last_seen++;
      words_seen++;
      if (words_seen == NB) dump_expect = 1'b0;
    end
    prev_v = hist_valid_o & ~reset;
    prev_rdy = hist_ready_i;
    prev_bin = hist_bin_o;
    prev_cnt = hist_count_o;
    prev_last = hist_last_o;
  end

  // Drives frame_q as a frame; counted pixels go into the reference histogram.
  task automatic run_frame(input int line_len, input bit gaps, input bit first_on_rise);
    int col = 0;
    npix = 0;
    fv_i = 1'b1;
    if (!first_on_rise) begin
      lv_i = 1'b0;
      pd_i = PIX_W'($urandom);
      tick();
    end
    foreach (frame_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        lv_i = 1'b0;
        pd_i = PIX_W'($urandom);
        tick();
      end
      lv_i = 1'b1;
      pd_i = frame_q[i];
      model_hist[int'(frame_q[i]) >> (PIX_W - BIN_BITS)]++;
      npix++;
      tick();
      col++;
      if (col == line_len) begin
        col = 0;
        lv_i = 1'b0;
        pd_i = PIX_W'($urandom);
        tick();
        tick();
      end
    end
    lv_i = 1'b0;
    tick();
    fv_i = 1'b0;
  endtask

  task automatic start_dump();
    for (int b = 0; b < NB; b++) begin
      exp_hist[b] = model_hist[b];
      model_hist[b] = 0;
      got_hist[b] = -1;
    end
    words_seen = 0;
    last_seen = 0;
    got_sum = 0;
    dump_expect = 1'b1;
  endtask

  task automatic wait_dump(input string name, input int bound, output int cycles);
    cycles = 0;
    while (words_seen < NB && cycles < bound) begin
      tick();
      cycles++;
    end
    check({name, "_words"}, words_seen, NB);
    check({name, "_last_count"}, last_seen, 1);
    dump_expect = 1'b0;
    tick();
    tick();
    check({name, "_busy_after"}, busy_o, 0);
  endtask

  task automatic wait_clear(input string name);
    int cnt = 0;
    do begin
      tick();
      cnt++;
      check({name, "_outs"}, {hist_valid_o, hist_bin_o, hist_count_o, hist_last_o, frame_drop_o}, 0);
    end while (busy_o && cnt < 400);
    check({name, "_busy_cycles"}, cnt, 256);
  endtask

  initial begin
    int cyc;
    for (int b = 0; b < NB; b++) model_hist[b] = 0;

    // Reset and power-on clear
    repeat (3) tick();
    check("reset_busy", busy_o, 1);
    check("reset_outs", {hist_valid_o, hist_bin_o, hist_count_o, hist_last_o, frame_drop_o}, 0);
    reset = 1'b0;
    wait_clear("clear");
    repeat (4) tick();
    check("idle_busy", busy_o, 0);

    // 4 lines x 16 pixels of 0x3FF, twice
    for (int rep = 0; rep < 2; rep++) begin
      frame_q.delete();
      for (int i = 0; i < 64; i++) frame_q.push_back(10'h3FF);
      run_frame(16, 1'b0, 1'b0);
      start_dump();
      wait_dump("full_frame", 400, cyc);
      check("full_frame_latency_ok", (cyc <= 262) ? 1 : 0, 1);
      check("full_frame_bin255", got_hist[255], 64);
      check("full_frame_bin0", got_hist[0], 0);
      check("full_frame_bin254", got_hist[254], 0);
      check("full_frame_sum", got_sum, 64);
      repeat (3) tick();
    end

    // Back-to-back hazards, first pixel on the fv rise cycle
    frame_q = '{10'h004, 10'h004, 10'h007, 10'h004, 10'h008};
    run_frame(5, 1'b0, 1'b1);
    start_dump();
    wait_dump("forward", 400, cyc);
    check("forward_bin1", got_hist[1], 4);
    check("forward_bin2", got_hist[2], 1);
    check("forward_sum", got_sum, 5);

    // Random frames, random ready; narrow range provokes address hazards
    rand_ready = 1'b1;
    for (int rep = 0; rep < 3; rep++) begin
      frame_q.delete();
      for (int i = 0; i < 120; i++)
        frame_q.push_back((rep == 1) ? PIX_W'($urandom_range(0, 15)) : PIX_W'($urandom));
      run_frame(20, 1'b1, rep[0]);
      start_dump();
      wait_dump("random", 3000, cyc);
      check("random_sum", got_sum, npix);
    end

    // New frame starting mid-dump is dropped and the dump is unaffected
    frame_q.delete();
    for (int i = 0; i < 60; i++) frame_q.push_back(PIX_W'($urandom_range(0, 31)));
    run_frame(12, 1'b1, 1'b0);
    start_dump();
    begin
      int drops0 = drop_seen;
      int w = 0;
      while (words_seen < 50 && w < 2000) begin tick(); w++; end
      check("drop_reached_mid_dump", (words_seen >= 50 && words_seen < NB) ? 1 : 0, 1);
      fv_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
        lv_i = 1'b1;
        pd_i = PIX_W'($urandom);
        tick();
      end
      wait_dump("drop_dump", 3000, cyc);
      check("drop_sum", got_sum, npix);
      for (int i = 0; i < 10; i++) begin
        pd_i = PIX_W'($urandom);
        tick();
      end
      lv_i = 1'b0;
      fv_i = 1'b0;
      repeat (6) tick();
      check("drop_pulses", drop_seen - drops0, 1);
    end
    rand_ready = 1'b0;

    // Reset mid-ACCUM, then a clean 10-pixel frame
    fv_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lv_i = 1'b1;
      pd_i = 10'h200;
      tick();
    end
    reset = 1'b1;
    tick();
    tick();
    fv_i = 1'b0;
    lv_i = 1'b0;
    tick();
    reset = 1'b0;
    wait_clear("abort_clear");
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back(10'h100);
    run_frame(10, 1'b0, 1'b0);
    start_dump();
    wait_dump("abort_frame", 400, cyc);
    check("abort_bin64", got_hist[64], 10);
    check("abort_bin128", got_hist[128], 0);
    check("abort_sum", got_sum, 10);
    check("total_drops", drop_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
